// File: rtl/swap_skid_buffer.sv
// ---------------------------------------------------------------------------
// swap_skid_buffer
//
// This is an elastic valid/ready pipeline stage for the byte-swapped input
// path. Each accepted word is stored in a register. If swap was high when the
// word was accepted, its upper and lower halves are exchanged before storage.
// The stage holds two entries: a main (head) register that drives out_data,
// and a skid register. With two entries, in_ready can be a registered signal
// and the stage still sustains one word per cycle.
//
// Optional feature: define SWAP_SKID_COUNT_EN to add the xfer_count port and
// a 16-bit counter of accepted words.
//
// Ports:
//   CLK         rising-edge clock
//   ASYNCRESET  asynchronous, active-high reset
//   in_data     upstream word
//   in_valid    upstream word valid
//   in_ready    stage can accept (registered)
//   swap        1 = exchange the halves of in_data on capture
//   out_data    head word (registered)
//   out_valid   head word valid (registered)
//   out_ready   downstream accepts
//   xfer_count  accepted-word count, wraps at 16 bits (SWAP_SKID_COUNT_EN only)
// ---------------------------------------------------------------------------
module swap_skid_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             swap,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SWAP_SKID_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] captured;

  // Handshakes are judged on the registered flags. That keeps in_ready free
  // of any combinational path from out_ready.
  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // The swap is applied once, at capture. After that, a stored word never
  // changes.
  assign captured = swap ? {in_data[HALF-1:0], in_data[WIDTH-1:HALF]} : in_data;

  // This block updates the state, both data registers and the registered
  // handshake flags together. Each flag is written to match the state being
  // entered, so the outputs always agree with the state.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (accept) begin
            main_q      <= captured;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= captured;
          end else if (accept) begin
            // Downstream has stalled, so the new word goes into the skid
            // register. in_ready drops on the same edge.
            skid_q      <= captured;
            state       <= FULL;
            in_ready_q  <= 1'b0;
          end else if (emit) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (emit) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef SWAP_SKID_COUNT_EN
  logic [15:0] count_q;

  // This counts accepted words. It wraps naturally from 0xFFFF to 0x0000.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign xfer_count = count_q;
`endif

endmodule

// File: tb/tb_swap_skid_buffer.sv
// ---------------------------------------------------------------------------
// tb_swap_skid_buffer
//
// This bench drives directed steps and then random steps into
// swap_skid_buffer. It compares the DUT against a reference model. The model
// is a word queue with a capacity of two, plus a flag that becomes true on
// the first clock edge after reset.
// ---------------------------------------------------------------------------
module tb_swap_skid_buffer;

  logic        CLK;
  logic        ASYNCRESET;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        swap;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef SWAP_SKID_COUNT_EN
  logic [15:0] xfer_count;
`endif

  swap_skid_buffer #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .swap       (swap),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef SWAP_SKID_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0] model_q[$];
  bit          model_live = 0;
  logic [15:0] model_count = 16'd0;

  function automatic logic [15:0] half_swap(input logic [15:0] d);
    return ((d & 16'h00FF) << 8) | (d >> 8);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negative edge. Compares the DUT outputs with the model.
  task automatic checkOutput(input string tag);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, model_q.size() > 0});
    check({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, model_live && model_q.size() < 2});
    if (model_q.size() > 0)
      check({tag, ".out_data"}, out_data, model_q[0]);
`ifdef SWAP_SKID_COUNT_EN
    check({tag, ".xfer_count"}, xfer_count, model_count);
`endif
  endtask

  // Drives one cycle's worth of inputs, then advances the model at the
  // clock edge, then checks the DUT at the following negative edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic s,
                               input logic r, input string tag);
    bit can_take;
    bit can_give;
    in_valid  = v;
    in_data   = d;
    swap      = s;
    out_ready = r;
    can_take  = model_live && model_q.size() < 2;
    can_give  = model_q.size() > 0;
    @(posedge CLK);
    if (can_give && r) void'(model_q.pop_front());
    if (can_take && v) begin
      model_q.push_back(s ? half_swap(d) : d);
      model_count = model_count + 16'd1;
    end
    model_live = 1;
    @(negedge CLK);
    checkOutput(tag);
  endtask

  // Asserts reset in the middle of a cycle and checks that the outputs clear
  // right away, without waiting for a clock edge. Reset is released at the
  // next negative edge.
  task automatic doReset(input string tag);
    #2 ASYNCRESET = 1'b1;
    #1;
    check({tag, ".rst_out_valid"}, {15'd0, out_valid}, 16'd0);
    check({tag, ".rst_out_data"}, out_data, 16'h0000);
    check({tag, ".rst_in_ready"}, {15'd0, in_ready}, 16'd0);
    model_q.delete();
    model_live  = 0;
    model_count = 16'd0;
    @(negedge CLK);
    ASYNCRESET = 1'b0;
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    in_valid   = 1'b0;
    in_data    = 16'h0000;
    swap       = 1'b0;
    out_ready  = 1'b0;
    #12;
    check("init.out_valid", {15'd0, out_valid}, 16'd0);
    check("init.out_data", out_data, 16'h0000);
    check("init.in_ready", {15'd0, in_ready}, 16'd0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    // The first edge after reset only raises in_ready.
    applyStimulus(0, 16'h0000, 0, 0, "wake");
    check("wake.in_ready_const", {15'd0, in_ready}, 16'd1);

    // Single word with swap, then without swap.
    applyStimulus(1, 16'hAB12, 1, 1, "single_swap");
    check("single_swap.const", out_data, 16'h12AB);
    applyStimulus(0, 16'h0000, 0, 1, "single_drain");
    applyStimulus(1, 16'hAB12, 0, 1, "single_plain");
    check("single_plain.const", out_data, 16'hAB12);
    applyStimulus(0, 16'h0000, 0, 1, "single_drain2");

    // Toggling out_ready while the stage is empty must have no effect.
    applyStimulus(0, 16'h0000, 0, 0, "idle_r0");
    applyStimulus(0, 16'h0000, 0, 1, "idle_r1");

    // Streaming of 0x0102..0x0F10 with alternating swap.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      w = 16'((2 * i + 1) * 256 + (2 * i + 2));
      applyStimulus(1, w, 1'(i % 2 == 0), 1, "stream");
    end
    applyStimulus(0, 16'h0000, 0, 1, "stream_drain");

    // Backpressure and skid. 0x3333 arrives while the stage is full and must
    // be ignored.
    applyStimulus(1, 16'h1111, 0, 0, "bp1");
    applyStimulus(1, 16'h2222, 0, 0, "bp2");
    check("bp2.in_ready_const", {15'd0, in_ready}, 16'd0);
    applyStimulus(1, 16'h3333, 0, 0, "bp3_rejected");
    check("bp3.hold_const", out_data, 16'h1111);
    applyStimulus(0, 16'h0000, 0, 1, "bp_rel1");
    check("bp_rel1.const", out_data, 16'h2222);
    applyStimulus(0, 16'h0000, 0, 1, "bp_rel2");
    check("bp_rel2.empty_const", {15'd0, out_valid}, 16'd0);

    // Reset while the stage is full.
    applyStimulus(1, 16'hDEAD, 0, 0, "full1");
    applyStimulus(1, 16'hBEEF, 0, 0, "full2");
    doReset("full_rst");
    applyStimulus(0, 16'h0000, 0, 1, "post_rst_wake");
    applyStimulus(1, 16'h5A5A, 0, 1, "post_rst_word");
    check("post_rst_word.const", out_data, 16'h5A5A);
    applyStimulus(0, 16'h0000, 0, 1, "post_rst_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), "random");
    end

    // Random traffic with heavier backpressure.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), "random_bp");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // This watchdog guarantees that the bench ends even if the sequence above
  // hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
